// File: rtl/madgwick_wb_top.sv
// Wishbone attitude peripheral: gyro/accel sample registers plus one fixed-point
// quaternion integration step per software start. Optional debug ports: MADGWICK_DEBUG_EN.
module madgwick_wb_top #(
  parameter int ACC_WIDTH  = 11,
  parameter int GYRO_WIDTH = 14,
  parameter int GYRO_FRAC  = 10,
  parameter int DT_SHIFT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            adr_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  input  logic                  we_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o
`ifdef MADGWICK_DEBUG_EN
  ,
  output logic [ACC_WIDTH-1:0]  a_x_debug,
  output logic [ACC_WIDTH-1:0]  a_y_debug,
  output logic [ACC_WIDTH-1:0]  a_z_debug,
  output logic [GYRO_WIDTH-1:0] w_x_debug,
  output logic [GYRO_WIDTH-1:0] w_y_debug,
  output logic [GYRO_WIDTH-1:0] w_z_debug,
  output logic [31:0]           q_w_debug,
  output logic [31:0]           q_x_debug,
  output logic [31:0]           q_y_debug,
  output logic [31:0]           q_z_debug,
  output logic                  enable_debug,
  output logic                  start_debug,
  output logic                  done_debug,
  output logic                  busy_debug
`endif
);

  localparam int          PW    = 32 + GYRO_WIDTH;
  localparam int          SHIFT = GYRO_FRAC + 1 + DT_SHIFT;
  localparam logic [31:0] Q_ONE = 32'h4000_0000;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CALC, ST_UPDATE, ST_DONE} state_e;

  state_e                        state_q;
  logic                          enable_q, start_q, done_q;
  logic [ACC_WIDTH-1:0]          acc_q  [3];
  logic [GYRO_WIDTH-1:0]         gyro_q [3];
  logic [31:0]                   quat_q [4];
  logic signed [GYRO_WIDTH-1:0]  ws_q   [3];
  logic signed [31:0]            qs_q   [4];
  logic signed [PW-1:0]          prod_q [4][3];
  logic signed [47:0]            sum_d   [4];
  logic signed [47:0]            delta_d [4];
  logic [31:0]                   quat_new_d [4];
  logic [31:0]                   rdata_d;
  logic                          ack_d;
  logic                          unused_bits;

  function automatic logic [31:0] sext_acc(input logic [ACC_WIDTH-1:0] v);
    return {{(32-ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
  endfunction

  function automatic logic [31:0] sext_gyro(input logic [GYRO_WIDTH-1:0] v);
    return {{(32-GYRO_WIDTH){v[GYRO_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [47:0] wide(input logic signed [PW-1:0] p);
    return 48'(p);
  endfunction

  // Clamp to Q2.30 range when the 49-bit sum no longer fits in 32 bits.
  function automatic logic [31:0] sat32(input logic signed [48:0] v);
    if (v[48:31] == '0 || v[48:31] == '1) return v[31:0];
    else if (v[48])                       return 32'h8000_0000;
    else                                  return 32'h7FFF_FFFF;
  endfunction

  assign ack_d       = stb_i & cyc_i & ~ack_o;
  assign unused_bits = ^{adr_i[1:0], dat_i[31:GYRO_WIDTH]};

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rdata_d = '0;
    case (adr_i[5:2])
      4'd0:    rdata_d = {29'd0, done_q, start_q, enable_q};
      4'd1:    rdata_d = sext_acc(acc_q[0]);
      4'd2:    rdata_d = sext_acc(acc_q[1]);
      4'd3:    rdata_d = sext_acc(acc_q[2]);
      4'd4:    rdata_d = sext_gyro(gyro_q[0]);
      4'd5:    rdata_d = sext_gyro(gyro_q[1]);
      4'd6:    rdata_d = sext_gyro(gyro_q[2]);
      4'd7:    rdata_d = quat_q[0];
      4'd8:    rdata_d = quat_q[1];
      4'd9:    rdata_d = quat_q[2];
      4'd10:   rdata_d = quat_q[3];
      default: rdata_d = '0;
    endcase
  end

  // Quaternion derivative q * (0, w), scaled by dt/2 through one arithmetic shift.
  always_comb begin
    sum_d[0] = -(wide(prod_q[1][0]) + wide(prod_q[2][1]) + wide(prod_q[3][2]));
    sum_d[1] =   wide(prod_q[0][0]) + wide(prod_q[2][2]) - wide(prod_q[3][1]);
    sum_d[2] =   wide(prod_q[0][1]) - wide(prod_q[1][2]) + wide(prod_q[3][0]);
    sum_d[3] =   wide(prod_q[0][2]) + wide(prod_q[1][1]) - wide(prod_q[2][0]);
    for (int k = 0; k < 4; k++) begin
      delta_d[k]    = sum_d[k] >>> SHIFT;
      quat_new_d[k] = sat32(49'(qs_q[k]) + 49'(delta_d[k]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      enable_q <= 1'b0;
      start_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= '0;
        gyro_q[i] <= '0;
      end
    end else begin
      ack_o <= ack_d;
      if (ack_d) begin
        if (we_i) begin
          case (adr_i[5:2])
            4'd0: begin
              enable_q <= dat_i[0];
              start_q  <= dat_i[1];
            end
            4'd1:    acc_q[0]  <= dat_i[ACC_WIDTH-1:0];
            4'd2:    acc_q[1]  <= dat_i[ACC_WIDTH-1:0];
            4'd3:    acc_q[2]  <= dat_i[ACC_WIDTH-1:0];
            4'd4:    gyro_q[0] <= dat_i[GYRO_WIDTH-1:0];
            4'd5:    gyro_q[1] <= dat_i[GYRO_WIDTH-1:0];
            4'd6:    gyro_q[2] <= dat_i[GYRO_WIDTH-1:0];
            default: ;
          endcase
        end else begin
          dat_o <= rdata_d;
        end
      end
    end
  end

  // NOTE: the small register arrays are reset so an async reset mid-step leaves no partial state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      quat_q[0] <= Q_ONE;
      quat_q[1] <= '0;
      quat_q[2] <= '0;
      quat_q[3] <= '0;
      for (int i = 0; i < 4; i++) begin
        qs_q[i] <= '0;
        for (int j = 0; j < 3; j++) prod_q[i][j] <= '0;
      end
      for (int j = 0; j < 3; j++) ws_q[j] <= '0;
    end else if (!enable_q) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      quat_q[0] <= Q_ONE;
      quat_q[1] <= '0;
      quat_q[2] <= '0;
      quat_q[3] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            for (int j = 0; j < 3; j++) ws_q[j] <= gyro_q[j];
            for (int i = 0; i < 4; i++) qs_q[i] <= quat_q[i];
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
              prod_q[i][j] <= PW'(qs_q[i]) * PW'(ws_q[j]);
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          for (int k = 0; k < 4; k++) quat_q[k] <= quat_new_d[k];
          done_q  <= 1'b1;
          state_q <= ST_UPDATE;
        end
        ST_UPDATE: state_q <= ST_DONE;
        ST_DONE: begin
          if (!start_q) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MADGWICK_DEBUG_EN
  assign a_x_debug    = acc_q[0];
  assign a_y_debug    = acc_q[1];
  assign a_z_debug    = acc_q[2];
  assign w_x_debug    = gyro_q[0];
  assign w_y_debug    = gyro_q[1];
  assign w_z_debug    = gyro_q[2];
  assign q_w_debug    = quat_q[0];
  assign q_x_debug    = quat_q[1];
  assign q_y_debug    = quat_q[2];
  assign q_z_debug    = quat_q[3];
  assign enable_debug = enable_q;
  assign start_debug  = start_q;
  assign done_debug   = done_q;
  assign busy_debug   = (state_q != ST_IDLE) && (state_q != ST_DONE);
`endif

endmodule

// File: tb/tb_madgwick_wb_top.sv
// Directed self-checking bench for madgwick_wb_top: register map, two update
// steps with hand-computed quaternions, enable/start interplay and async reset.
module tb_madgwick_wb_top;

  logic        clk;
  logic        rst_n;
  logic [5:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i, stb_i, cyc_i;
  logic        ack_o;

  int checks = 0;
  int errors = 0;

  madgwick_wb_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we_i  (we_i),
    .stb_i (stb_i),
    .cyc_i (cyc_i),
    .ack_o (ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wb_cycle(input logic [5:0] a, input logic [31:0] d, input logic we,
                          output logic [31:0] rd);
    int n;
    @(negedge clk);
    adr_i = a; dat_i = d; we_i = we; stb_i = 1'b1; cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_o && n < 8);
    check("ack", {31'd0, ack_o}, 32'd1);
    rd = dat_o;
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_cycle(a, d, 1'b1, unused_rd);
  endtask

  task automatic read_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_cycle(a, 32'h0, 1'b0, rd);
    check(tag, rd, exp);
  endtask

  task automatic poll_done();
    logic [31:0] rd;
    int n;
    n = 0;
    do begin
      wb_cycle(6'h00, 32'h0, 1'b0, rd);
      n++;
    end while (!rd[2] && n < 20);
    check("done_poll", {31'd0, rd[2]}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    read_check("rst_ctrl", 6'h00, 32'h0000_0000);
    read_check("rst_qw",   6'h1C, 32'h4000_0000);
    read_check("rst_qx",   6'h20, 32'h0000_0000);

    wb_write(6'h00, 32'h1);
    read_check("ctrl_en", 6'h00, 32'h0000_0001);
    wb_write(6'h04, 32'h7B8);
    read_check("ax_sext", 6'h04, 32'hFFFF_FFB8);
    wb_write(6'h1C, 32'h1234_5678);
    read_check("qw_ro", 6'h1C, 32'h4000_0000);
    wb_write(6'h3C, 32'hDEAD_BEEF);
    read_check("bad_adr", 6'h2C, 32'h0000_0000);

    wb_write(6'h10, 32'hFFFF_3F1F);
    wb_write(6'h14, 32'h5C);
    wb_write(6'h18, 32'h5C);
    read_check("wx_sext", 6'h10, 32'hFFFF_FF1F);

    // First step from identity; w_x is overwritten mid-step and must not matter.
    wb_write(6'h00, 32'h3);
    wb_write(6'h10, 32'h0);
    poll_done();
    read_check("s1_ctrl", 6'h00, 32'h0000_0007);
    read_check("s1_qw",   6'h1C, 32'h4000_0000);
    read_check("s1_qx",   6'h20, 32'hFFF8_F800);
    read_check("s1_qy",   6'h24, 32'h0002_E000);
    read_check("s1_qz",   6'h28, 32'h0002_E000);
    read_check("wx_new",  6'h10, 32'h0000_0000);

    wb_write(6'h00, 32'h1);
    read_check("ack_ctrl", 6'h00, 32'h0000_0001);
    read_check("hold_qx",  6'h20, 32'hFFF8_F800);

    // Second step from the non-identity quaternion with w = (0, 92, 92).
    wb_write(6'h00, 32'h3);
    read_check("busy_ctrl", 6'h00, 32'h0000_0003);
    poll_done();
    read_check("s2_qw", 6'h1C, 32'h3FFF_FFBD);
    read_check("s2_qx", 6'h20, 32'hFFF8_F800);
    read_check("s2_qy", 6'h24, 32'h0005_C050);
    read_check("s2_qz", 6'h28, 32'h0005_BFAF);
    wb_write(6'h00, 32'h1);

    wb_write(6'h00, 32'h0);
    read_check("dis_qw",   6'h1C, 32'h4000_0000);
    read_check("dis_qy",   6'h24, 32'h0000_0000);
    read_check("dis_ctrl", 6'h00, 32'h0000_0000);

    wb_write(6'h00, 32'h2);
    repeat (6) @(posedge clk);
    read_check("noen_qx",   6'h20, 32'h0000_0000);
    read_check("noen_ctrl", 6'h00, 32'h0000_0002);

    // Async reset landing in CALC.
    wb_write(6'h00, 32'h3);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'd0, ack_o}, 32'd0);
    check("mid_rst_dat", dat_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    read_check("mid_rst_ctrl", 6'h00, 32'h0000_0000);
    read_check("mid_rst_qw",   6'h1C, 32'h4000_0000);
    read_check("mid_rst_qy",   6'h24, 32'h0000_0000);
    read_check("mid_rst_qz",   6'h28, 32'h0000_0000);
    read_check("mid_rst_wy",   6'h14, 32'h0000_0000);

    wb_cycle(6'h00, 32'h0, 1'b0, rd);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/madgwick_wb_top.md
# madgwick_wb_top

Wishbone-slave attitude peripheral for the SweRVolf SoC. It holds memory-mapped accelerometer and gyroscope sample registers, and runs one fixed-point quaternion update step per software-issued start. It exposes the resulting orientation quaternion as read-only registers. The CPU sequences each step through a control register (enable, start, done).

## Interface
- ACC_WIDTH, 11: signed accelerometer sample width.
- GYRO_WIDTH, 14: signed gyro sample width.
- GYRO_FRAC, 10: gyro fractional bits (rad/s).
- DT_SHIFT, 8: update period dt = 2^-DT_SHIFT s.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- adr_i  in  6  Wishbone byte address.
- dat_i  in  32  write data.
- dat_o  out  32  read data; reset 0.
- we_i  in  1  write enable.
- stb_i  in  1  strobe.
- cyc_i  in  1  bus cycle.
- ack_o  out  1  acknowledge; reset 0.

## Operation
- Register map (word aligned, adr_i[1:0] ignored):
  - 0x00 CTRL: bit0 enable (RW), bit1 start (RW), bit2 done (RO), other bits read 0.
  - 0x04/0x08/0x0C a_x/a_y/a_z (RW). The low ACC_WIDTH bits are stored; reads return them sign-extended to 32 bits.
  - 0x10/0x14/0x18 w_x/w_y/w_z (RW). The low GYRO_WIDTH bits are stored; reads return them sign-extended.
  - 0x1C/0x20/0x24/0x28 q_w/q_x/q_y/q_z (RO). Format is signed Q2.30.
  - Any other address reads 0; writes to it are ignored but still acknowledged.
- Reset values: every register is 0, except the quaternion, which is identity (0x40000000, 0, 0, 0).
- enable=0 holds the quaternion at identity, forces the FSM to IDLE and clears done.
- FSM states: IDLE, LOAD, CALC, UPDATE, DONE.
  - IDLE→LOAD when enable=1 and start=1. LOAD snapshots the gyro registers and the quaternion.
  - LOAD→CALC: the 12 products q·w are computed and registered, each 46-bit signed.
  - CALC→UPDATE: the new quaternion is written and done is set.
    - Δq_w = −(q_x·w_x + q_y·w_y + q_z·w_z)
    - Δq_x = q_w·w_x + q_y·w_z − q_z·w_y
    - Δq_y = q_w·w_y − q_x·w_z + q_z·w_x
    - Δq_z = q_w·w_z + q_x·w_y − q_y·w_x
    - Sums use 48-bit arithmetic, then an arithmetic right shift by GYRO_FRAC+1+DT_SHIFT.
    - q_new = q + Δq, saturated to 0x7FFFFFFF / 0x80000000.
  - UPDATE→DONE.
  - DONE→IDLE on the first cycle with start=0; this clears done.
- Accelerometer registers are stored and readable only; this revision applies no gravity correction.
- Clearing start while in LOAD/CALC/UPDATE does not abort the step. The step completes, then DONE falls through to IDLE.
- The quaternion is not renormalised.

## Timing
- ack_o is registered: ack_o <= stb_i & cyc_i & ~ack_o.
  - It is a one-cycle pulse, one cycle after the request.
  - A master holding stb_i sees one ack per two cycles.
- A write commits on the same edge that raises ack_o.
- dat_o is loaded on that same edge and holds until the next read acknowledge.
- Writing start=1 (edge E) puts the FSM in LOAD at E+1, CALC at E+2, UPDATE at E+3.
  - done and the new quaternion are visible from E+3.
- An asynchronous rst_n assertion mid-step restores the reset values immediately. No partial quaternion is retained.
- A bus write to w_* during a step has no effect on that step, because of the LOAD snapshot.

## Configuration
- MADGWICK_DEBUG_EN defined adds these output ports, all combinational copies of internal state:
  - a_x_debug, a_y_debug, a_z_debug (ACC_WIDTH)
  - w_x_debug, w_y_debug, w_z_debug (GYRO_WIDTH)
  - q_w_debug, q_x_debug, q_y_debug, q_z_debug (32)
  - enable_debug, start_debug, done_debug, busy_debug (busy = FSM not IDLE/DONE)
- MADGWICK_DEBUG_EN undefined: these ports do not exist; bus behaviour is identical.

## Test plan
- Reset, read 0x00 → 0x00000000. Read 0x1C → 0x40000000. Read 0x20 → 0.
- Write CTRL 0x01, read back → 0x01. Write a_x=0x7B8, read 0x04 → 0xFFFFFFB8.
- Enable. Write w_x=0x3F1F (−225), w_y=0x5C, w_z=0x5C. Write CTRL 0x03, poll until done. Then read:
  - 0x00 → 0x07
  - q_w → 0x40000000
  - q_x → 0xFFF8F800
  - q_y → 0x0002E000
  - q_z → 0x0002E000
- After done, write CTRL 0x01 → read 0x01. Quaternion unchanged.
- Write CTRL 0x00 after an update → quaternion reads identity, done 0. Start with enable=0 → no update.
- Assert rst_n low during CALC → ack_o=0, dat_o=0, quaternion identity, CTRL 0.
